// File: rtl/float_op_sequencer.sv
// float_op_sequencer: issues add/sub/mul commands to the FU, counts its latency and returns tagged results; optional feature macro FLOAT_SEQ_ZERO_BYPASS_EN
module float_op_sequencer #(
  parameter int N_MANTISSE = 23,
  parameter int N_EXPOSANT = 8,
  parameter int MUL_LAT = 2,
  parameter int ADD_LAT = 3,
  parameter int TAG_W = 4,
  localparam int W = 1 + N_EXPOSANT + N_MANTISSE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             fu_start,
  output logic [1:0]       fu_op,
  output logic [W-1:0]     fu_a,
  output logic [W-1:0]     fu_b,
  input  logic [W-1:0]     fu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [TAG_W-1:0] tag;
  logic accept, reserved, bypass;
  assign accept = cmd_valid && cmd_ready;
  assign reserved = cmd_op == 2'b11;
`ifdef FLOAT_SEQ_ZERO_BYPASS_EN
  assign bypass = cmd_op == 2'b10 && (cmd_a[W-2 -: N_EXPOSANT] == '0 || cmd_b[W-2 -: N_EXPOSANT] == '0);
`else
  assign bypass = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign fu_start = state == ISSUE;
  assign res_valid = state == RESP;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state: reserved ops and zero-exponent muls skip the FU entirely
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ((reserved || bypass) ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = cnt == 4'd0 ? RESP : WAIT;
      RESP:    state_nx = res_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // command capture, latency counting and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      tag <= '0;
      fu_op <= '0;
      fu_a <= '0;
      fu_b <= '0;
      res_data <= '0;
      res_tag <= '0;
      res_err <= 1'b0;
    end else begin
      if (accept) begin
        fu_op <= cmd_op;
        fu_a <= cmd_a;
        fu_b <= cmd_b;
        tag <= cmd_tag;
        if (reserved || bypass) begin
          res_data <= reserved ? '0 : {cmd_a[W-1] ^ cmd_b[W-1], {(W-1){1'b0}}};
          res_tag <= cmd_tag;
          res_err <= reserved;
        end
      end
      if (state == ISSUE) cnt <= fu_op == 2'b10 ? 4'(MUL_LAT - 1) : 4'(ADD_LAT - 1);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == WAIT && cnt == 4'd0) begin
        res_data <= fu_result;
        res_tag <= tag;
        res_err <= 1'b0;
      end
    end
  end
endmodule

// File: doc/float_op_sequencer.md
Name: float_op_sequencer

Overview:
- Command-level controller for the coprocessor's floating-point unit (FU).
- Accepts one operation at a time (add/sub/mul) from the host side over a valid/ready channel and issues it to the FU with a one-cycle start pulse.
- Counts the FU's fixed, per-operation latency, captures the result and presents it with the request tag on a valid/ready response channel.
- Sits between the coprocessor command decoder and the float_mul/float_addsub datapath.

Parameters:
- N_MANTISSE, 23, mantissa width (1..23)
- N_EXPOSANT, 8, exponent width (2..8)
- MUL_LAT, 2, FU cycles from fu_start to valid fu_result for mul (1..15)
- ADD_LAT, 3, FU cycles from fu_start to valid fu_result for add/sub (1..15)
- TAG_W, 4, width of request tag

Derived: W = 1 + N_EXPOSANT + N_MANTISSE (float word: sign, exponent, mantissa, MSB first).

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 reserved
- cmd_a  in  W  operand 1
- cmd_b  in  W  operand 2
- cmd_tag  in  TAG_W  request identifier
- fu_start  out  1  one-cycle issue pulse to the FU
- fu_op  out  2  opcode held to the FU
- fu_a  out  W  operand 1 held to the FU
- fu_b  out  W  operand 2 held to the FU
- fu_result  in  W  FU result, valid exactly the programmed latency after fu_start
- res_valid  out  1  response present
- res_ready  in  1  consumer accepts the response
- res_data  out  W  result word
- res_tag  out  TAG_W  tag of the completed command
- res_err  out  1  command used the reserved opcode
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - cmd_ready=1 (high in IDLE only), fu_start=0, res_valid=0, res_err=0, busy=0.
  - fu_op, fu_a, fu_b, res_data and res_tag are all 0.
  - Latency counter is 0; state is IDLE.
- Reset asserted in any state forces these values on the next edge. An in-flight FU result is discarded and no response is produced.
- A command is accepted on a cycle where cmd_valid && cmd_ready. cmd_op, cmd_a, cmd_b and cmd_tag are registered into fu_op, fu_a, fu_b and an internal tag.
- FSM:
  - IDLE: on accept with op != 11, go to ISSUE. On accept with op == 11, go to RESP with res_err=1 and res_data=0; no FU issue.
  - ISSUE (1 cycle): fu_start=1. Counter loaded with MUL_LAT-1 for mul, otherwise ADD_LAT-1. Go to WAIT.
  - WAIT: counter decrements each cycle. When the counter is 0, capture fu_result into res_data and go to RESP.
  - RESP: res_valid=1, with res_data, res_tag and res_err held stable. When res_ready is high, go to IDLE.
- Timing: accept at edge 0, fu_start high in cycle 1, fu_result sampled at cycle 1+LAT, res_valid rises at cycle 2+LAT.
- Back-to-back commands: if res_ready is high in the first RESP cycle, the next command can be accepted 1 cycle later.
- Throughput is one outstanding command; cmd_ready stays low from accept until the cycle after the response handshake.
- fu_op, fu_a and fu_b stay stable from ISSUE until the next accept.
- res_valid must not drop without res_ready. A res_ready asserted while res_valid=0 is ignored.
- cmd_valid asserted while cmd_ready=0 is ignored; no queuing.

Optional Feature:
- Macro: FLOAT_SEQ_ZERO_BYPASS_EN.
- When defined: a mul command where either operand's exponent field is 0 skips ISSUE/WAIT.
  - The sequencer goes directly from IDLE to RESP.
  - res_data = {a.sign ^ b.sign, zero exponent, zero mantissa}.
  - res_valid rises 1 cycle after accept; fu_start is never pulsed.
- When undefined: such operations go through the FU like any other mul.

Test Plan:
- Reset mid-WAIT: mul accepted, reset pulsed at cycle 2 -> all outputs return to reset values next edge; no res_valid follows; next command is accepted normally.
- Mul, defaults: a=0x3FC00000 (1.5), b=0x40000000 (2.0), tag=5; FU model returns 0x40400000 two cycles after fu_start -> fu_start pulses exactly once at cycle 1; res_valid at cycle 4 with res_data=0x40400000, res_tag=5, res_err=0.
- Add with backpressure: a=0x3F800000, b=0x3F800000, op=00; FU returns 0x40000000 after 3 cycles; res_ready held low for 4 cycles -> res_valid at cycle 5 stays high with stable data until res_ready; cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake.
- Reserved opcode 11, tag=9 -> no fu_start; res_valid at cycle 1 with res_err=1, res_data=0, res_tag=9.
- Back-to-back: sub then mul, each with res_ready tied high -> second command accepted 1 cycle after the first handshake; fu_op=01 then 10; ADD_LAT/MUL_LAT timing observed for each respective command.
- Zero bypass (macro defined): mul with a=0x80000000, b=0x3F800000 -> no fu_start; res_valid at cycle 1 with res_data=0x80000000. Macro undefined -> normal FU path with fu_start at cycle 1.
